// File: rtl/bram_stream_reader.sv
// Burst reader for a 2-cycle-latency block RAM, streamed out through a 4-entry
// first-word-fall-through buffer with valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start_in; a zero-length start only pulses done_out
// RUN   | issuing RAM reads while buffer space (fifo + inflight) allows
// DRAIN | all reads issued; emptying the buffer until the last word pops
module bram_stream_reader #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_DEPTH = 1024,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int FIFO_DEPTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [AW-1:0]        base_addr_in,
  input  logic [AW:0]          len_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [AW-1:0]        ram_addr_out,
  output logic                 ram_en_out,
  output logic                 ram_regce_out,
  input  logic [RAM_WIDTH-1:0] ram_data_in,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 last_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [AW:0] ONE_W   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(RAM_DEPTH);
  localparam logic [2:0]  FDEPTH  = 3'(FIFO_DEPTH);

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        base_q;
  logic [AW:0]          len_q, issued_q;
  logic                 en_d1_q, en_d2_q, last_d1_q, last_d2_q;
  logic                 zero_done_q;
  logic [RAM_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [1:0]           wr_ptr_q, rd_ptr_q;
  logic [2:0]           count_q;

  logic       issue, issue_last, push, pop, head_last, start_ok;
  logic [2:0] occupancy;
  logic [AW:0] addr_sum, addr_wrap;

  // Reads still in the RAM pipeline reserve their buffer slot; pops give no credit.
  assign occupancy  = count_q + {2'b00, en_d1_q} + {2'b00, en_d2_q};
  assign issue      = (state_q == S_RUN) && (occupancy < FDEPTH);
  assign issue_last = issue && (issued_q == len_q - ONE_W);
  assign start_ok   = (state_q == S_IDLE) && start_in && (len_in != '0);

  assign addr_sum  = {1'b0, base_q} + issued_q;
  assign addr_wrap = (addr_sum >= DEPTH_W) ? addr_sum - DEPTH_W : addr_sum;

  assign push      = en_d2_q;
  assign valid_out = (count_q != 3'd0);
  assign pop       = valid_out && ready_in;
  assign head_last = fifo_last_q[rd_ptr_q];

  assign busy_out      = (state_q != S_IDLE);
  assign ram_en_out    = issue;
  assign ram_regce_out = en_d1_q;
  assign ram_addr_out  = addr_wrap[AW-1:0];
  assign data_out      = valid_out ? fifo_data_q[rd_ptr_q] : '0;
  assign last_out      = valid_out && head_last;
  assign done_out      = zero_done_q || ((state_q == S_DRAIN) && pop && head_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (issue_last) state_d = S_DRAIN;
      S_DRAIN: if (pop && head_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      en_d1_q     <= 1'b0;
      en_d2_q     <= 1'b0;
      last_d1_q   <= 1'b0;
      last_d2_q   <= 1'b0;
      zero_done_q <= 1'b0;
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      en_d1_q     <= issue;
      en_d2_q     <= en_d1_q;
      last_d1_q   <= issue_last;
      last_d2_q   <= last_d1_q;
      zero_done_q <= (state_q == S_IDLE) && start_in && (len_in == '0);

      if (start_ok) begin
        base_q   <= base_addr_in;
        len_q    <= len_in;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + ONE_W;
      end

      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_data_in;
        fifo_last_q[wr_ptr_q] <= last_d2_q;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;

      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a table of bursts plus hand-written
// sequences for exact timing, zero length and reset mid-burst.
module tb_bram_stream_reader;

  logic        clk;
  logic        rst, start, ready;
  logic [9:0]  base_a;
  logic [10:0] len_i;
  logic        busy, done, ram_en, ram_regce, valid, last_o;
  logic [9:0]  ram_addr;
  logic [17:0] ram_data, ram_r1, data_o;

  bram_stream_reader dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .base_addr_in(base_a),
    .len_in(len_i), .busy_out(busy), .done_out(done), .ram_addr_out(ram_addr),
    .ram_en_out(ram_en), .ram_regce_out(ram_regce), .ram_data_in(ram_data),
    .data_out(data_o), .valid_out(valid), .ready_in(ready), .last_out(last_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model with RAM[i] = i and a 2-cycle read (array stage + output register).
  always_ff @(posedge clk) begin
    if (ram_en) ram_r1 <= 18'(ram_addr);
    if (ram_regce) ram_data <= ram_r1;
  end

  typedef struct {
    int base; int len; int mode;
    int exp_first; int exp_final; int exp_words; int exp_stall_issues;
  } vec_t;

  vec_t vecs[7];
  int errors = 0, checks = 0;
  int cyc, done_cnt, any_valid, any_busy, early_en, stab_err;
  logic prev_stall;
  logic [17:0] prev_data;
  logic prev_last;
  logic [17:0] got_data[$];
  logic got_last[$];
  logic [9:0] addr_q[$];
  logic tr_en[16], tr_valid[16], tr_last[16], tr_done[16];
  logic [9:0] tr_addr[16];
  logic [17:0] tr_data[16];

  task automatic chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_data.delete(); got_last.delete(); addr_q.delete();
    cyc = 0; done_cnt = 0; any_valid = 0; any_busy = 0; early_en = 0; stab_err = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tr_en[i] = 0; tr_valid[i] = 0; tr_last[i] = 0; tr_done[i] = 0;
      tr_addr[i] = '0; tr_data[i] = '0;
    end
  endtask

  // Samples mid-cycle, then advances to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (cyc < 16) begin
      tr_en[cyc] = ram_en; tr_addr[cyc] = ram_addr; tr_valid[cyc] = valid;
      tr_data[cyc] = data_o; tr_last[cyc] = last_o; tr_done[cyc] = done;
    end
    if (valid && ready) begin got_data.push_back(data_o); got_last.push_back(last_o); end
    if (ram_en) begin addr_q.push_back(ram_addr); if (cyc < 20) early_en++; end
    if (done) done_cnt++;
    if (valid) any_valid++;
    if (busy) any_busy++;
    if (prev_stall && valid && (data_o != prev_data || last_o != prev_last)) stab_err++;
    prev_stall = valid && !ready; prev_data = data_o; prev_last = last_o;
    @(posedge clk); #1;
    cyc++;
  endtask

  function automatic logic ready_for(int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return (cyc >= 20);
    return ($urandom_range(0, 1) != 0);
  endfunction

  task automatic run_burst(int base, int len, int mode);
    clear_mon();
    base_a = 10'(base); len_i = 11'(len); start = 1'b1; ready = ready_for(mode);
    step();
    start = 1'b0;
    for (int n = 0; n < len * 4 + 60 && done_cnt == 0; n++) begin
      ready = ready_for(mode);
      step();
    end
    ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_last"}, last_o, 0);
    chk({tag, "_en"}, ram_en, 0);
    chk({tag, "_regce"}, ram_regce, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_data"}, data_o, 0);
  endtask

  initial begin
    vecs[0] = '{5,    3,    1, 5,    7,    3,    -1};
    vecs[1] = '{1022, 4,    1, 1022, 1,    4,    -1};
    vecs[2] = '{0,    1,    1, 0,    0,    1,    -1};
    vecs[3] = '{100,  16,   2, 100,  115,  16,   4};
    vecs[4] = '{1020, 9,    3, 1020, 4,    9,    -1};
    vecs[5] = '{7,    1024, 3, 7,    6,    1024, -1};
    vecs[6] = '{1023, 2,    2, 1023, 0,    2,    2};

    rst = 1'b1; start = 1'b1; base_a = 10'd9; len_i = 11'd5; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    check_outputs_zero("reset");

    // Exact cycle timing of a short burst.
    run_burst(5, 3, 1);
    begin
      int bad_en = 0, bad_addr = 0, bad_valid = 0, bad_data = 0, bad_last = 0, bad_done = 0;
      for (int c = 0; c < 9; c++) begin
        if (tr_en[c] != (c >= 1 && c <= 3)) bad_en++;
        if (c >= 1 && c <= 3 && tr_addr[c] != 10'(4 + c)) bad_addr++;
        if (tr_valid[c] != (c >= 4 && c <= 6)) bad_valid++;
        if (c >= 4 && c <= 6 && tr_data[c] != 18'(c + 1)) bad_data++;
        if (tr_last[c] != (c == 6)) bad_last++;
        if (tr_done[c] != (c == 6)) bad_done++;
      end
      chk("timing_en", bad_en, 0);
      chk("timing_addr", bad_addr, 0);
      chk("timing_valid", bad_valid, 0);
      chk("timing_data", bad_data, 0);
      chk("timing_last", bad_last, 0);
      chk("timing_done", bad_done, 0);
      chk("timing_regce_gone", ram_regce, 0);
    end

    // Zero-length start.
    clear_mon();
    base_a = 10'd3; len_i = 11'd0; start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("len0_done_c0", tr_done[0], 0);
    chk("len0_done_c1", tr_done[1], 1);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_issues", addr_q.size(), 0);
    chk("len0_valid", any_valid, 0);
    chk("len0_busy", any_busy, 0);

    // Reset with one word buffered and two reads in flight.
    clear_mon();
    base_a = 10'd40; len_i = 11'd8; start = 1'b1; ready = 1'b0;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("prerst_valid", tr_valid[4], 1);
    chk("prerst_issues", addr_q.size(), 4);
    check_outputs_zero("midrst");
    any_valid = 0; ready = 1'b1;
    repeat (6) step();
    chk("postrst_valid", any_valid, 0);
    run_burst(0, 2, 1);
    chk("postrst_words", got_data.size(), 2);
    chk("postrst_w0", got_data.size() > 0 ? got_data[0] : 18'h3FFFF, 0);
    chk("postrst_w1", got_data.size() > 1 ? got_data[1] : 18'h3FFFF, 1);

    // Table of bursts.
    for (int v = 0; v < 7; v++) begin
      int bad_stream, bad_addr;
      run_burst(vecs[v].base, vecs[v].len, vecs[v].mode);
      bad_stream = 0; bad_addr = 0;
      for (int k = 0; k < vecs[v].len; k++) begin
        logic [17:0] exp_w;
        exp_w = 18'((vecs[v].base + k) % 1024);
        if (k < got_data.size()) begin
          if (got_data[k] != exp_w) bad_stream++;
          if (got_last[k] != (k == vecs[v].len - 1)) bad_stream++;
        end
        if (k < addr_q.size() && addr_q[k] != exp_w[9:0]) bad_addr++;
      end
      chk($sformatf("v%0d_words", v), got_data.size(), vecs[v].exp_words);
      chk($sformatf("v%0d_issues", v), addr_q.size(), vecs[v].exp_words);
      chk($sformatf("v%0d_stream", v), bad_stream, 0);
      chk($sformatf("v%0d_addr", v), bad_addr, 0);
      chk($sformatf("v%0d_first", v), got_data.size() > 0 ? got_data[0] : 18'h3FFFF, vecs[v].exp_first);
      chk($sformatf("v%0d_final", v), got_data.size() > 0 ? got_data[$] : 18'h3FFFF, vecs[v].exp_final);
      chk($sformatf("v%0d_done", v), done_cnt, 1);
      chk($sformatf("v%0d_stable", v), stab_err, 0);
      chk($sformatf("v%0d_idle", v), busy, 0);
      if (vecs[v].mode == 2) chk($sformatf("v%0d_stall_issues", v), early_en, vecs[v].exp_stall_issues);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- RAM_WIDTH, 18, data word width.
- RAM_DEPTH, 1024, RAM entries; AW = clog2(RAM_DEPTH).
- FIFO_DEPTH, 4, output buffer entries; fixed at 4, not overridable.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk_in  in  1  sole clock.
- rst_in  in  1  reset, synchronous, active-high.
- start_in  in  1  begin burst; sampled only in IDLE.
- base_addr_in  in  AW  first RAM address.
- len_in  in  AW+1  words to read, 0..RAM_DEPTH.
- busy_out  out  1  high in RUN/DRAIN.
- done_out  out  1  one-cycle completion pulse.
- ram_addr_out  out  AW  RAM address.
- ram_en_out  out  1  RAM enable; high only on issue cycles.
- ram_regce_out  out  1  RAM output-register enable.
- ram_data_in  in  RAM_WIDTH  RAM output data; 2-cycle read latency.
- data_out  out  RAM_WIDTH  stream data.
- valid_out  out  1  stream valid.
- ready_in  in  1  stream ready.
- last_out  out  1  marks final word of burst; qualified by valid_out.
REQ-003 Clock and reset SHALL be: one clock, clk_in; reset rst_in, synchronous, active-high.

Function
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-005 IDLE SHALL behave as follows:
- start_in=1, len_in>0: latch base/len, enter RUN.
- start_in=1, len_in=0: pulse done_out next cycle, remain IDLE, issue no reads.
REQ-006 start_in in RUN/DRAIN SHALL be ignored.
REQ-007 An issue SHALL occur in RUN when (fifo_count + inflight) < FIFO_DEPTH, with these effects:
- ram_en_out=1.
- ram_addr_out = (base + issued_count) mod RAM_DEPTH; address wraps past RAM_DEPTH-1 to 0.
REQ-008 ram_regce_out SHALL equal ram_en_out delayed one cycle.
REQ-009 ram_data_in SHALL be written into the FIFO in the cycle exactly two cycles after its issue; no same-cycle pop credit.
REQ-010 inflight SHALL be the count of issued-but-unwritten reads (0..2).
REQ-011 RUN SHALL move to DRAIN on the cycle the final (len-th) address issues.
REQ-012 FIFO output SHALL be first-word-fall-through:
- valid_out = (fifo_count>0).
- data_out = head entry.
- Pop on valid_out && ready_in.
REQ-013 last_out SHALL be high only while the head entry is the len-th word of the burst.
REQ-014 DRAIN SHALL return to IDLE on the cycle the last word pops, with done_out=1 in that same cycle.
REQ-015 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-016 The FIFO SHALL never overflow; no push is ever dropped.
REQ-017 With ready_in held high: start in cycle 0 -> first issue cycle 1 -> first valid_out cycle 4 -> one word per cycle thereafter, no bubbles.
REQ-018 With ready_in low: issues SHALL stop once fifo_count + inflight = 4; data_out and last_out SHALL be held stable while valid_out=1 and ready_in=0.
REQ-019 len_in = RAM_DEPTH SHALL read every RAM entry exactly once, starting at base and wrapping.
REQ-020 Counters SHALL be AW+1 bits wide; no arithmetic overflow is permitted.

Reset
REQ-021 On rst_in=1 at a clock edge, the block SHALL:
- Enter IDLE; clear FIFO, inflight, and counters.
- Drive busy_out, done_out, valid_out, last_out, ram_en_out, ram_regce_out to 0; ram_addr_out to 0; data_out to 0.
REQ-022 Reset mid-burst SHALL discard in-flight RAM data; nothing is written to the FIFO in the two cycles after reset is released.
REQ-023 Reset SHALL take priority over start_in and over every other input in the same cycle.

Verification
REQ-024 RAM[i]=i, base=5, len=3, ready=1 -> ram_addr 5,6,7 in cycles 1-3; data 5,6,7 valid in cycles 4-6; last_out with 7; done_out in cycle 6.
REQ-025 RAM_DEPTH=1024, base=1022, len=4 -> addresses 1022,1023,0,1 in that order; data in that order; last_out with address 1's data.
REQ-026 len=16, ready_in=0 for 20 cycles then 1 -> exactly 4 issues before stall; no loss; all 16 words in order; done_out once.
REQ-027 len_in=0 -> done_out pulse next cycle; no ram_en_out; valid_out stays 0.
REQ-028 rst_in pulsed while 2 reads in flight and 1 word buffered -> all outputs 0 next cycle; no valid_out afterward; new start with base=0, len=2 -> 2 correct words.
REQ-029 Random ready_in at 50% over len=1024 -> stream equals RAM contents in order; no duplicates; done_out exactly once.
